mask_collector: RTL and testbench

Index-stream to bit-mask collector: the inverse of the `lzc` leading-zero/priority encoder in common_cells. It accepts a valid/ready stream of bit indices, sets the addressed bit in an accumulator and counts distinct bits. On the index flagged `last` it presents the completed mask, its population count and error flags on a valid/ready output. It sits beside the dummy IP as a sequential exerciser of the same common_cells dependency set and is gated by the same `ENABLE_DUMMY_VIP` define in the enclosing module.

---
 rtl/mask_collector_pkg.sv | 18 +
 rtl/mask_collector_if.sv | 29 ++
 rtl/idx_decoder.sv | 15 +
 rtl/mask_collector.sv | 91 +++++++++
 tb/tb_mask_collector.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mask_collector_pkg.sv
// Shared types and width helpers for the index-to-mask collector.
package mask_collector_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;

  // Same definition as the common_cells idx_width helper: at least one bit.
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned num_bits);
    return unsigned'($clog2(num_bits + 32'd1));
  endfunction

endpackage

// File: rtl/mask_collector_if.sv
// Index input stream and mask output stream of mask_collector; signal names
// are given from the collector's point of view.
interface mask_collector_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned IDX_WIDTH = mask_collector_pkg::idx_width(WIDTH);
  localparam int unsigned CNT_WIDTH = mask_collector_pkg::cnt_width(WIDTH);

  logic [IDX_WIDTH-1:0] idx_i;
  logic                 idx_last_i;
  logic                 idx_valid_i;
  logic                 idx_ready_o;
  logic [WIDTH-1:0]     mask_o;
  logic [CNT_WIDTH-1:0] cnt_o;
  logic                 dup_o;
  logic                 oor_o;
  logic                 mask_valid_o;
  logic                 mask_ready_i;

  modport slave (
    input  idx_i, idx_last_i, idx_valid_i, mask_ready_i,
    output idx_ready_o, mask_o, cnt_o, dup_o, oor_o, mask_valid_o
  );

  modport master (
    output idx_i, idx_last_i, idx_valid_i, mask_ready_i,
    input  idx_ready_o, mask_o, cnt_o, dup_o, oor_o, mask_valid_o
  );
endinterface

// File: rtl/idx_decoder.sv
// Combinational bit index to one-hot decoder with an in-range flag for
// non-power-of-two widths.
module idx_decoder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IDX_WIDTH = 5
) (
  input  logic [IDX_WIDTH-1:0] idx_i,
  output logic [WIDTH-1:0]     onehot_o,
  output logic                 in_range_o
);

  assign in_range_o = (32'(idx_i) < WIDTH);
  assign onehot_o   = in_range_o ? (WIDTH'(1) << idx_i) : '0;

endmodule

// File: rtl/mask_collector.sv
// Collects a stream of bit indices into a mask with distinct-bit count and
// duplicate / out-of-range flags; the frame is released on the last index.
module mask_collector
  import mask_collector_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic             flush_i,
  mask_collector_if.slave bus
);

  localparam int unsigned IDX_WIDTH = idx_width(WIDTH);
  localparam int unsigned CNT_WIDTH = cnt_width(WIDTH);

  state_e               state_q;
  logic [WIDTH-1:0]     mask_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 dup_q;
  logic                 oor_q;

  logic [WIDTH-1:0]     onehot;
  logic                 in_range;
  logic                 already_set;

  idx_decoder #(
    .WIDTH     (WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_idx_decoder (
    .idx_i      (bus.idx_i),
    .onehot_o   (onehot),
    .in_range_o (in_range)
  );

  assign already_set = |(mask_q & onehot);

  // Flush outranks both handshakes; the output handshake empties the frame
  // without accepting an index in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= COLLECT;
      mask_q  <= '0;
      cnt_q   <= '0;
      dup_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= COLLECT;
      mask_q  <= '0;
      cnt_q   <= '0;
      dup_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (bus.idx_valid_i) begin
            if (!in_range) begin
              oor_q <= 1'b1;
            end else if (already_set) begin
              dup_q <= 1'b1;
            end else begin
              mask_q <= mask_q | onehot;
              cnt_q  <= cnt_q + 1'b1;
            end
            if (bus.idx_last_i) begin
              state_q <= EMIT;
            end
          end
        end
        EMIT: begin
          if (bus.mask_ready_i) begin
            state_q <= COLLECT;
            mask_q  <= '0;
            cnt_q   <= '0;
            dup_q   <= 1'b0;
            oor_q   <= 1'b0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign bus.idx_ready_o  = (state_q == COLLECT);
  assign bus.mask_valid_o = (state_q == EMIT);
  assign bus.mask_o       = mask_q;
  assign bus.cnt_o        = cnt_q;
  assign bus.dup_o        = dup_q;
  assign bus.oor_o        = oor_q;

endmodule

// File: tb/tb_mask_collector.sv
// Bench for mask_collector at WIDTH=32 (dut A) and WIDTH=12 (dut B).
module tb_mask_collector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_a = 1'b0;
  logic flush_b = 1'b0;

  always #5 clk = ~clk;

  mask_collector_if #(.WIDTH(32)) a_if ();
  mask_collector_if #(.WIDTH(12)) b_if ();

  mask_collector #(.WIDTH(32)) u_dut_a (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush_a),
    .bus     (a_if.slave)
  );

  mask_collector #(.WIDTH(12)) u_dut_b (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush_b),
    .bus     (b_if.slave)
  );

  typedef struct {
    logic [31:0] mask;
    logic [31:0] cnt;
    logic        dup;
    logic        oor;
  } exp_t;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] cnt;
    logic        dup;
    logic        oor;
    logic        valid;
    logic        ready;
  } out_t;

  typedef struct {
    bit          sel_b;
    int          n;
    int          idx [4];
    exp_t        exp;
  } vec_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  function automatic out_t get(input bit sel_b);
    out_t o;
    if (sel_b) begin
      o.mask = 32'(b_if.mask_o);  o.cnt = 32'(b_if.cnt_o);
      o.dup = b_if.dup_o;         o.oor = b_if.oor_o;
      o.valid = b_if.mask_valid_o; o.ready = b_if.idx_ready_o;
    end else begin
      o.mask = a_if.mask_o;       o.cnt = 32'(a_if.cnt_o);
      o.dup = a_if.dup_o;         o.oor = a_if.oor_o;
      o.valid = a_if.mask_valid_o; o.ready = a_if.idx_ready_o;
    end
    return o;
  endfunction

  task automatic drive(input bit sel_b, input int idx, input bit last, input bit valid);
    logic [31:0] v;
    v = 32'(idx);
    if (sel_b) begin
      b_if.idx_i = v[3:0]; b_if.idx_last_i = last; b_if.idx_valid_i = valid;
    end else begin
      a_if.idx_i = v[4:0]; a_if.idx_last_i = last; a_if.idx_valid_i = valid;
    end
  endtask

  task automatic set_ready(input bit sel_b, input bit r);
    if (sel_b) b_if.mask_ready_i = r;
    else       a_if.mask_ready_i = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the index until it is taken; the ready seen before an edge decides acceptance.
  task automatic send_idx(input bit sel_b, input int idx, input bit last);
    bit   done;
    out_t o;
    done = 1'b0;
    drive(sel_b, idx, last, 1'b1);
    for (int k = 0; k < 50 && !done; k++) begin
      o = get(sel_b);
      done = o.ready;
      tick();
    end
    if (!done) chk("idx_accept_timeout", 32'd0, 32'd1);
    drive(sel_b, 0, 1'b0, 1'b0);
  endtask

  task automatic expect_frame(input bit sel_b, input string nm);
    out_t o;
    exp_t e;
    o = get(sel_b);
    chk({nm, "_latency"}, 32'(o.valid), 32'd1);
    for (int k = 0; k < 20 && !o.valid; k++) begin
      tick();
      o = get(sel_b);
    end
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({nm, "_mask"}, o.mask, e.mask);
      chk({nm, "_cnt"},  o.cnt,  e.cnt);
      chk({nm, "_dup"},  32'(o.dup), 32'(e.dup));
      chk({nm, "_oor"},  32'(o.oor), 32'(e.oor));
      chk({nm, "_rdy_in_emit"}, 32'(o.ready), 32'd0);
    end
  endtask

  task automatic release_frame(input bit sel_b, input string nm);
    out_t o;
    set_ready(sel_b, 1'b1);
    tick();
    set_ready(sel_b, 1'b0);
    o = get(sel_b);
    chk({nm, "_rel_valid"}, 32'(o.valid), 32'd0);
    chk({nm, "_rel_ready"}, 32'(o.ready), 32'd1);
    chk({nm, "_rel_mask"},  o.mask, 32'd0);
    chk({nm, "_rel_cnt"},   o.cnt,  32'd0);
  endtask

  task automatic check_idle(input bit sel_b, input string nm);
    out_t o;
    o = get(sel_b);
    chk({nm, "_mask"},  o.mask, 32'd0);
    chk({nm, "_cnt"},   o.cnt,  32'd0);
    chk({nm, "_dup"},   32'(o.dup), 32'd0);
    chk({nm, "_oor"},   32'(o.oor), 32'd0);
    chk({nm, "_valid"}, 32'(o.valid), 32'd0);
    chk({nm, "_ready"}, 32'(o.ready), 32'd1);
  endtask

  function automatic vec_t mk(input bit sel_b, input int n, input int i0, input int i1,
                              input int i2, input int i3, input logic [31:0] m,
                              input int c, input bit d, input bit r);
    vec_t v;
    v.sel_b = sel_b; v.n = n;
    v.idx[0] = i0; v.idx[1] = i1; v.idx[2] = i2; v.idx[3] = i3;
    v.exp.mask = m; v.exp.cnt = 32'(c); v.exp.dup = d; v.exp.oor = r;
    return v;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] m, input int c);
    exp_t e;
    e.mask = m; e.cnt = 32'(c); e.dup = 1'b0; e.oor = 1'b0;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [8];
    out_t o;
    string nm;

    vecs[0] = mk(1'b0, 3, 0, 5, 31, 0,  32'h8000_0021, 3, 1'b0, 1'b0);
    vecs[1] = mk(1'b0, 3, 7, 7, 3, 0,   32'h0000_0088, 2, 1'b1, 1'b0);
    vecs[2] = mk(1'b1, 3, 11, 13, 0, 0, 32'h0000_0801, 2, 1'b0, 1'b1);
    vecs[3] = mk(1'b0, 1, 31, 0, 0, 0,  32'h8000_0000, 1, 1'b0, 1'b0);
    vecs[4] = mk(1'b1, 2, 11, 11, 0, 0, 32'h0000_0800, 1, 1'b1, 1'b0);
    vecs[5] = mk(1'b1, 1, 15, 0, 0, 0,  32'h0000_0000, 0, 1'b0, 1'b1);
    vecs[6] = mk(1'b0, 4, 1, 2, 3, 4,   32'h0000_001E, 4, 1'b0, 1'b0);
    vecs[7] = mk(1'b0, 4, 9, 9, 9, 12,  32'h0000_1200, 2, 1'b1, 1'b0);

    drive(1'b0, 0, 1'b0, 1'b0);
    drive(1'b1, 0, 1'b0, 1'b0);
    set_ready(1'b0, 1'b0);
    set_ready(1'b1, 1'b0);

    #1;
    check_idle(1'b0, "in_reset_a");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_idle(1'b0, "post_reset_a");
    check_idle(1'b1, "post_reset_b");

    for (int v = 0; v < 8; v++) begin
      nm = $sformatf("vec%0d", v);
      for (int j = 0; j < vecs[v].n; j++) begin
        if (j == vecs[v].n - 1) sb.push_back(vecs[v].exp);
        send_idx(vecs[v].sel_b, vecs[v].idx[j], j == vecs[v].n - 1);
      end
      expect_frame(vecs[v].sel_b, nm);
      release_frame(vecs[v].sel_b, nm);
    end

    // Output stall with the input stream still offering a frame.
    send_idx(1'b0, 2, 1'b0);
    sb.push_back(mk_exp(32'h0000_0044, 2));
    send_idx(1'b0, 6, 1'b1);
    expect_frame(1'b0, "stall");
    drive(1'b0, 20, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      o = get(1'b0);
      chk($sformatf("stall%0d_mask", k),  o.mask, 32'h0000_0044);
      chk($sformatf("stall%0d_cnt", k),   o.cnt, 32'd2);
      chk($sformatf("stall%0d_valid", k), 32'(o.valid), 32'd1);
      chk($sformatf("stall%0d_ready", k), 32'(o.ready), 32'd0);
    end
    set_ready(1'b0, 1'b1);
    tick();
    set_ready(1'b0, 1'b0);
    o = get(1'b0);
    chk("stall_hs_ready", 32'(o.ready), 32'd1);
    chk("stall_hs_valid", 32'(o.valid), 32'd0);
    chk("stall_hs_mask",  o.mask, 32'd0);
    sb.push_back(mk_exp(32'h0010_0000, 1));
    tick();
    drive(1'b0, 0, 1'b0, 1'b0);
    expect_frame(1'b0, "after_stall");
    release_frame(1'b0, "after_stall");

    // Flush mid-frame, then a fresh frame.
    send_idx(1'b0, 1, 1'b0);
    send_idx(1'b0, 2, 1'b0);
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    check_idle(1'b0, "flush_mid");
    sb.push_back(mk_exp(32'h0000_0010, 1));
    send_idx(1'b0, 4, 1'b1);
    expect_frame(1'b0, "post_flush");

    // Flush in EMIT withdraws valid without a handshake.
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    check_idle(1'b0, "flush_emit");

    // Flush outranks an input handshake in the same cycle.
    flush_a = 1'b1;
    drive(1'b0, 8, 1'b1, 1'b1);
    tick();
    flush_a = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0);
    check_idle(1'b0, "flush_prio");

    // Asynchronous reset between clock edges in the middle of a frame.
    send_idx(1'b0, 3, 1'b0);
    send_idx(1'b0, 9, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle(1'b0, "async_rst");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    sb.push_back(mk_exp(32'h0000_0040, 1));
    send_idx(1'b0, 6, 1'b1);
    expect_frame(1'b0, "post_rst");
    release_frame(1'b0, "post_rst");

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
